arc4_encrypt: RTL
=================

Name: arc4_encrypt

Overview:
- ARC4 encryptor. It is the writer side of the ciphertext memory that the crack/decrypt path reads.
- Accepts a 24-bit key on an en/rdy handshake and reads a length-prefixed plaintext from pt memory.
- Writes the length-prefixed ciphertext into ct memory, in the same format the crack engines consume.
- Uses an external 256x8 S memory for the cipher state. Used to generate test ciphertexts on-chip.

Parameters:
- none

Ports:
- clk        input   1   system clock; all logic on rising edge
- rst_n      input   1   reset; synchronous, active-low (sampled on rising clk edge)
- en         input   1   start request; sampled only while rdy=1
- rdy        output  1   1 = idle and able to accept en
- key        input   24  ARC4 key; key[23:16]=byte0, key[15:8]=byte1, key[7:0]=byte2; captured on accepted en
- s_addr     output  8   S memory address
- s_rddata   input   8   S memory read data
- s_wrdata   output  8   S memory write data
- s_wren     output  1   S memory write enable
- pt_addr    output  8   plaintext memory address (read-only)
- pt_rddata  input   8   plaintext memory read data
- ct_addr    output  8   ciphertext memory address
- ct_wrdata  output  8   ciphertext write data
- ct_wren    output  1   ciphertext write enable

Behaviour:
- Memories:
  - All three are single-port synchronous RAMs with 1-cycle read latency: address presented in cycle N, data valid in cycle N+1.
  - A write takes effect at the clock edge where wren=1.
  - Never drive s_wren and read S in the same cycle.
- Reset (rst_n=0 at clock edge):
  - state=IDLE, rdy=1, s_wren=0, ct_wren=0, all addresses 0, internal i/j/k/len=0.
  - Reset mid-operation aborts immediately; no further memory writes occur. Partial ct contents are left as they are.
- Handshake:
  - En is accepted on an edge where rdy=1 and en=1; key is latched on that edge.
  - rdy=0 from the next cycle until completion.
  - en while rdy=0 is ignored. The same request is never re-run; en held high after completion starts a new run.
  - rdy rises in the cycle after the final ct write.
- Message format:
  - pt[0] = L (0..255); pt[1..L] = plaintext bytes.
  - ct[0] = L; ct[k] = pt[k] XOR pad[k] for k=1..L.
- State machine:
  - IDLE: rdy=1; accept en -> INIT.
  - INIT: write s[i]=i for i=0..255, one per cycle (256 cycles); i wraps to 0 -> KSA.
  - KSA: for i=0..255:
    - j = (j + s[i] + keybyte[i mod 3]) mod 256, with j starting at 0.
    - Swap s[i] and s[j]: read s[i], read s[j], write s[i]<-old s[j], write s[j]<-old s[i].
    - i==j is legal; the result must leave s[i] unchanged.
    - After i=255 -> LEN.
  - LEN: read pt[0], latch L, write ct[0]=L.
    - L==0 -> DONE, with no other ct writes.
    - Otherwise i=0, j=0, k=1 -> PRGA.
  - PRGA: per byte:
    - i=i+1; read s[i]; j=j+s[i]; read s[j]; swap (two writes).
    - Read s[(s[i]+s[j]) mod 256] = pad; read pt[k]; write ct[k]=pt[k]^pad.
    - k==L -> DONE, else k=k+1.
  - DONE: one cycle, wrens=0 -> IDLE (rdy=1).
- Arithmetic: all index sums are 8-bit with wrap-around (mod 256); the k loop ends at L=255 without overflow.
- Ordering: each ct address is written exactly once per run, in increasing order 0..L. No writes ever go to pt.
- Wren pulses are exactly one cycle per write.
- Total latency must be ≤ 256 + 256·6 + 4 + L·10 cycles from accept to rdy=1.

Test Plan:
- Known vector: key=24'h4B6579 ("Key"), pt = {9, "Plaintext"}. Required: ct = {09, BB F3 16 E8 D9 40 AF 0A D3}; rdy returns 1.
- L=0: key=24'h000000, pt[0]=0. Required: exactly one ct write (addr 0, data 00), then rdy=1.
- L=255, key=24'h1A2B3C, random pt:
  - Required: 256 ct writes at addresses 0..255 in order.
  - Re-running the encryptor with pt replaced by the ct bytes (same key) reproduces the original pt bytes.
- Handshake: pulse en while busy.
  - Required: ignored; exactly one run's writes occur.
  - A key change on the port mid-run does not affect the ct output.
- Reset mid-KSA: assert rst_n=0 for 1 cycle during KSA.
  - Required: rdy=1 and both wrens=0 the cycle after.
  - A subsequent en with the known vector produces the correct ciphertext.
- i==j swap: a key chosen so that some KSA step has j==i (checked in a model). Required: S memory contents match the reference model after INIT+KSA, i.e. a permutation of 0..255.

Source files
------------

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: builds the cipher state in an external 256x8 S RAM from a
// 24-bit key, then streams a length-prefixed plaintext from pt RAM into a
// length-prefixed ciphertext in ct RAM. All RAMs have 1-cycle read latency.
`timescale 1ns/1ps
module arc4_encrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  // RD* states put an address on the RAM, WAIT* states cover the read
  // latency, and the following state consumes the data.
  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RDI, ST_K_WAITI, ST_K_RDJ, ST_K_WAITJ, ST_K_WRI, ST_K_WRJ,
    ST_LEN,
    ST_P_RDI, ST_P_WAITI, ST_P_RDJ, ST_P_WAITJ, ST_P_WRI, ST_P_WRJ,
    ST_P_RDPAD, ST_P_WAITPAD, ST_P_XOR,
    ST_DONE
  } state_t;

  state_t      state_q;
  logic        rdy_q;
  logic [7:0]  s_addr_q, s_wrdata_q, pt_addr_q, ct_addr_q, ct_wrdata_q;
  logic        s_wren_q, ct_wren_q;
  logic [7:0]  i_q, j_q, k_q, len_q;
  logic [1:0]  kidx_q;
  logic [23:0] key_q;
  logic [7:0]  si_q, sj_q, ptb_q;

  logic [7:0]  kbyte_d, j_ksa_d, j_prga_d, i_inc_d, pad_addr_d;

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;

  // Index arithmetic shared by the KSA and PRGA steps (all sums wrap mod 256).
  always_comb begin
    kbyte_d = key_q[23:16];
    if (kidx_q == 2'd1)      kbyte_d = key_q[15:8];
    else if (kidx_q == 2'd2) kbyte_d = key_q[7:0];
    j_ksa_d    = j_q + s_rddata + kbyte_d;
    j_prga_d   = j_q + s_rddata;
    i_inc_d    = i_q + 8'd1;
    pad_addr_d = si_q + sj_q;
  end

  // Control FSM with registered memory-interface outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b1;
      s_wren_q  <= 1'b0;
      ct_wren_q <= 1'b0;
      s_addr_q  <= 8'd0;
      pt_addr_q <= 8'd0;
      ct_addr_q <= 8'd0;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      k_q       <= 8'd0;
      len_q     <= 8'd0;
      kidx_q    <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            key_q     <= key;
            rdy_q     <= 1'b0;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            kidx_q    <= 2'd0;
            // pt[0] is fetched now and stays on the read port until LEN.
            pt_addr_q <= 8'd0;
            state_q   <= ST_INIT;
          end
        end

        ST_INIT: begin
          s_addr_q   <= i_q;
          s_wrdata_q <= i_q;
          s_wren_q   <= 1'b1;
          i_q        <= i_inc_d;
          if (i_q == 8'hFF) state_q <= ST_K_RDI;
        end

        ST_K_RDI: begin
          s_wren_q <= 1'b0;
          s_addr_q <= i_q;
          state_q  <= ST_K_WAITI;
        end
        ST_K_WAITI: state_q <= ST_K_RDJ;
        ST_K_RDJ: begin
          si_q     <= s_rddata;
          j_q      <= j_ksa_d;
          s_addr_q <= j_ksa_d;
          kidx_q   <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state_q  <= ST_K_WAITJ;
        end
        ST_K_WAITJ: state_q <= ST_K_WRI;
        // s[j] was read before either write, so i==j writes the same byte twice.
        ST_K_WRI: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= ST_K_WRJ;
        end
        ST_K_WRJ: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          i_q        <= i_inc_d;
          state_q    <= (i_q == 8'hFF) ? ST_LEN : ST_K_RDI;
        end

        ST_LEN: begin
          s_wren_q    <= 1'b0;
          len_q       <= pt_rddata;
          ct_addr_q   <= 8'd0;
          ct_wrdata_q <= pt_rddata;
          ct_wren_q   <= 1'b1;
          i_q         <= 8'd0;
          j_q         <= 8'd0;
          k_q         <= 8'd1;
          state_q     <= (pt_rddata == 8'd0) ? ST_DONE : ST_P_RDI;
        end

        ST_P_RDI: begin
          ct_wren_q <= 1'b0;
          s_wren_q  <= 1'b0;
          i_q       <= i_inc_d;
          s_addr_q  <= i_inc_d;
          pt_addr_q <= k_q;
          state_q   <= ST_P_WAITI;
        end
        ST_P_WAITI: state_q <= ST_P_RDJ;
        ST_P_RDJ: begin
          si_q     <= s_rddata;
          j_q      <= j_prga_d;
          s_addr_q <= j_prga_d;
          state_q  <= ST_P_WAITJ;
        end
        ST_P_WAITJ: begin
          ptb_q   <= pt_rddata;
          state_q <= ST_P_WRI;
        end
        ST_P_WRI: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= ST_P_WRJ;
        end
        ST_P_WRJ: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          state_q    <= ST_P_RDPAD;
        end
        ST_P_RDPAD: begin
          s_wren_q <= 1'b0;
          s_addr_q <= pad_addr_d;
          state_q  <= ST_P_WAITPAD;
        end
        ST_P_WAITPAD: state_q <= ST_P_XOR;
        ST_P_XOR: begin
          ct_addr_q   <= k_q;
          ct_wrdata_q <= ptb_q ^ s_rddata;
          ct_wren_q   <= 1'b1;
          if (k_q == len_q) begin
            state_q <= ST_DONE;
          end else begin
            k_q     <= k_q + 8'd1;
            state_q <= ST_P_RDI;
          end
        end

        ST_DONE: begin
          s_wren_q  <= 1'b0;
          ct_wren_q <= 1'b0;
          rdy_q     <= 1'b1;
          state_q   <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
